// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM encodings and op-class helpers for the iterative multiply/divide unit.
// Combinational helpers only; no latency or backpressure of their own.
package muldiv_unit_pkg;

    localparam int LENGTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } mdState_t;

    function automatic logic isDivOp(input mdOp_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input mdOp_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/result bundle between issue logic (master) and the multiply/divide unit (slave).
// Pure wiring; busy is the only backpressure, and the issuer must hold the instruction while it is high.
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = LENGTH
);
    logic             start;
    mdOp_t            op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             wen_hilo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi_out, lo_out, wen_hilo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi_out, lo_out, wen_hilo
    );
endinterface

// File: rtl/muldiv_unit_step.sv
// One shift-add (multiply) or restoring subtract-compare-shift (divide) iteration on magnitudes.
// Purely combinational: zero latency, no backpressure.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] hiIn,
    input  logic [WIDTH-1:0] loIn,
    input  logic [WIDTH-1:0] bIn,
    output logic [WIDTH-1:0] hiNext,
    output logic [WIDTH-1:0] loNext
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, hiIn} + (loIn[0] ? {1'b0, bIn} : '0);
        shifted = {hiIn, loIn[WIDTH-1]};
        ge      = shifted >= {1'b0, bIn};
        // Remainder stays below the divisor, so the difference always fits in WIDTH bits when ge.
        diff    = shifted[WIDTH-1:0] - bIn;
        if (isDiv) begin
            hiNext = ge ? diff : shifted[WIDTH-1:0];
            loNext = {loIn[WIDTH-2:0], ge};
        end else begin
            hiNext = sum[WIDTH:1];
            loNext = {sum[0], loIn[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU, one bit per cycle; done/wen_hilo pulse WIDTH+2 cycles after start.
// No backpressure: start is ignored while busy, flush cancels CALC/FIX but not DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = LENGTH,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic rst,
    muldiv_unit_if.slave bus
);
    mdState_t           state;
    logic [CNT_W-1:0]   cnt;
    mdOp_t              opReg;
    logic               negRes;
    logic               negRem;
    logic               divZero;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [WIDTH-1:0]   bReg;
    logic [WIDTH-1:0]   hiStep;
    logic [WIDTH-1:0]   loStep;
    logic [WIDTH-1:0]   hiOutReg;
    logic [WIDTH-1:0]   loOutReg;
    logic               doneReg;

    logic               reqSigned;
    logic               reqDiv;
    logic               aSign;
    logic               bSign;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic               divOp;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    assign divOp = isDivOp(opReg);

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv  (divOp),
        .hiIn   (hiReg),
        .loIn   (loReg),
        .bIn    (bReg),
        .hiNext (hiStep),
        .loNext (loStep)
    );

    always_comb begin
        reqSigned = isSignedOp(bus.op);
        reqDiv    = isDivOp(bus.op);
        aSign     = bus.src_a[WIDTH-1];
        bSign     = bus.src_b[WIDTH-1];
        aMag      = (reqSigned && aSign) ? -bus.src_a : bus.src_a;
        bMag      = (reqSigned && bSign) ? -bus.src_b : bus.src_b;

        prodFix   = negRes ? -{hiReg, loReg} : {hiReg, loReg};
        fixHi     = prodFix[2*WIDTH-1:WIDTH];
        fixLo     = prodFix[WIDTH-1:0];
        if (divOp) begin
            // Divide-by-zero leaves the magnitude remainder equal to |src_a|; the dividend sign restores src_a.
            fixHi = negRem ? -hiReg : hiReg;
            fixLo = divZero ? '1 : (negRes ? -loReg : loReg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            opReg    <= MD_MULT;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
            divZero  <= 1'b0;
            hiReg    <= '0;
            loReg    <= '0;
            bReg     <= '0;
            hiOutReg <= '0;
            loOutReg <= '0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        opReg   <= bus.op;
                        negRes  <= reqSigned & (aSign ^ bSign);
                        negRem  <= reqSigned & reqDiv & aSign;
                        divZero <= reqDiv && (bus.src_b == '0);
                        hiReg   <= '0;
                        loReg   <= reqDiv ? aMag : bMag;
                        bReg    <= reqDiv ? bMag : aMag;
                        cnt     <= '0;
                        state   <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (bus.flush) begin
                        state <= MD_IDLE;
                    end else begin
                        hiReg <= hiStep;
                        loReg <= loStep;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    if (bus.flush) begin
                        state <= MD_IDLE;
                    end else begin
                        hiOutReg <= fixHi;
                        loOutReg <= fixLo;
                        doneReg  <= 1'b1;
                        state    <= MD_DONE;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state != MD_IDLE);
    assign bus.done     = doneReg;
    assign bus.wen_hilo = doneReg;
    assign bus.hi_out   = hiOutReg;
    assign bus.lo_out   = loOutReg;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Delivers the {hi, lo} result plus a one-cycle write enable to the HI/LO register write path.
- Raises busy so the hazard detection unit can stall IF/ID and bubble ID/EXE while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width (equals `LENGTH)
CNT_W, 6, iteration counter width; must hold values up to WIDTH

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
start  in  1  one-cycle request, sampled on the clk edge
op  in  2  operation code, sampled with start
src_a  in  WIDTH  multiplicand or dividend (forwarded SrcA)
src_b  in  WIDTH  multiplier or divisor (forwarded SrcB)
flush  in  1  cancel the current or requested operation
busy  out  1  high while the state is not IDLE
done  out  1  one-cycle pulse when the result is valid
hi_out  out  WIDTH  high product word or remainder
lo_out  out  WIDTH  low product word or quotient
wen_hilo  out  1  equal to done; HI/LO write enable

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all working registers=0, busy=0, done=0, wen_hilo=0, hi_out=0, lo_out=0. A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE. Cycle 0 is the cycle in which start is high.
- IDLE: on start=1 with flush=0, latch op and operand signs. For the signed ops (MULT, DIV), load the absolute values of src_a and src_b; for the unsigned ops, load the operands as given. Then counter=0 and go to CALC. start with flush=1 is dropped.
- CALC: one iteration per cycle, counter incremented each cycle. After WIDTH iterations (cycles 1..WIDTH) go to FIX.
- Multiply: shift-add on a 2*WIDTH product register, unsigned, on the magnitudes.
- Divide: restoring division. Partial remainder is WIDTH+1 bits; quotient bits shift into the low half.
- FIX (cycle WIDTH+1): apply signs and register hi_out/lo_out. Go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
- DONE (cycle WIDTH+2): done=1 and wen_hilo=1 for exactly this cycle. Go to IDLE. Default WIDTH=32 gives done in cycle 34.
- busy = (state != IDLE), so it is low during the start cycle itself and high in cycles 1..WIDTH+2. The hazard unit must stall dependent instructions on (start | busy).
- start while busy (including during DONE) is ignored; the issuing logic must hold the instruction.
- flush in CALC or FIX: go to IDLE on the next edge. No done pulse; hi_out/lo_out keep their previous values.
- flush during DONE: ignored; the result still commits.
- Divide by zero (src_b=0, DIV or DIVU): no trap.
  - Result: lo_out = all ones, hi_out = src_a unchanged.
  - Detected at start; still takes the full latency.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0. This is the natural result of the magnitude algorithm.
- hi_out and lo_out hold their last committed value between operations.

Decomposition:
- head.v holds the shared constants:
  - `MD_MULT=2'b00, `MD_MULTU=2'b01, `MD_DIV=2'b10, `MD_DIVU=2'b11
  - state encodings `MD_IDLE/`MD_CALC/`MD_FIX/`MD_DONE
  - reuse of `LENGTH
- One sub-module, muldiv_step: purely combinational single iteration (add-shift or subtract-compare-shift) selected by the op class. The FSM, counter and sign-fix logic stay in muldiv_unit.

Test Plan:
- MULTU, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, start in cycle 0 -> done/wen_hilo high only in cycle 34; hi_out=0xFFFFFFFE, lo_out=0x00000001; busy high in cycles 1-34.
- MULT, -3 * 7 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB. DIV, -7 / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIVU, 7 / 2 -> lo_out=3, hi_out=1.
- DIVU, 0x64 / 0 -> lo_out=0xFFFFFFFF, hi_out=0x00000064, done in cycle 34. DIV, 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- flush in cycle 10 of a DIV -> busy low from cycle 11, no done, hi_out/lo_out unchanged. A new MULTU 5*6 started in cycle 12 -> lo_out=30, hi_out=0, done in cycle 46.
- start pulsed in cycles 5 and 34 during an active operation -> both ignored; a single done pulse. A start in cycle 35 (state IDLE) is accepted.
- rst driven low asynchronously mid-CALC -> busy, done, hi_out and lo_out go to 0 immediately. After release, the next start behaves as from reset.
